// File: rtl/topk_stream_sorter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | topk_stream_sorter_if                                                      |
// | Beat input stream and top-k result bus of the streaming top-k selector.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface topk_stream_sorter_if #(
    parameter int DATAWIDTH = 8,
    parameter int LANES     = 4,
    parameter int K_MAX     = 8,
    parameter int LEN_W     = 8
);
    localparam int c_kw = $clog2(K_MAX) + 1;

    logic                             in_valid_i;
    logic                             in_ready_o;
    logic [LEN_W-1:0]                 in_len_i;
    logic [c_kw-1:0]                  k_i;
    logic                             sign_ctrl_i;
    logic                             desc_i;
    logic [LANES-1:0][DATAWIDTH-1:0]  x_i;
    logic                             out_valid_o;
    logic                             out_ready_i;
    logic [K_MAX-1:0][DATAWIDTH-1:0]  y_o;
    logic [c_kw-1:0]                  out_count_o;

    modport master (
        output in_valid_i, in_len_i, k_i, sign_ctrl_i, desc_i, x_i, out_ready_i,
        input  in_ready_o, out_valid_o, y_o, out_count_o
    );

    modport slave (
        input  in_valid_i, in_len_i, k_i, sign_ctrl_i, desc_i, x_i, out_ready_i,
        output in_ready_o, out_valid_o, y_o, out_count_o
    );
endinterface
`default_nettype wire

// File: rtl/topk_stream_sorter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | topk_stream_sorter                                                         |
// | Reduces each frame of LANES-wide beats to its k best elements, one         |
// | element inserted per cycle into a sorted result array.                     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module topk_stream_sorter #(
    parameter int DATAWIDTH = 8,
    parameter int LANES     = 4,
    parameter int K_MAX     = 8,
    parameter int LEN_W     = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    topk_stream_sorter_if.slave    bus
);
    localparam int c_kw = $clog2(K_MAX) + 1;
    localparam int c_lw = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_INSERT    = 2'd1,
        S_WAIT_BEAT = 2'd2,
        S_OUT       = 2'd3
    } state_t;

    state_t                           state_q;
    logic [LANES-1:0][DATAWIDTH-1:0]  beat_q;
    logic [LEN_W-1:0]                 rem_q;
    logic [c_kw-1:0]                  k_eff_q;
    logic                             sign_q;
    logic                             desc_q;
    logic [c_lw-1:0]                  lane_q;
    logic [K_MAX-1:0][DATAWIDTH-1:0]  res_q;
    logic [c_kw-1:0]                  count_q;
    logic                             in_ready_q;
    logic                             out_valid_q;

    logic [K_MAX-1:0][DATAWIDTH-1:0]  res_d;
    logic [c_kw-1:0]                  count_d;
    logic [LEN_W-1:0]                 rem_d;
    logic [c_kw-1:0]                  w_k_eff;
    logic [c_kw-1:0]                  w_pos;
    logic [DATAWIDTH-1:0]             w_cur;

    function automatic logic f_beats(input logic [DATAWIDTH-1:0] a,
                                     input logic [DATAWIDTH-1:0] b,
                                     input logic                 sgn,
                                     input logic                 dsc);
        logic gt;
        logic lt;
        if (sgn) begin
            gt = $signed(a) > $signed(b);
            lt = $signed(a) < $signed(b);
        end else begin
            gt = a > b;
            lt = a < b;
        end
        return dsc ? gt : lt;
    endfunction

    always_comb begin
        if (bus.k_i == '0)
            w_k_eff = c_kw'(1);
        else if (bus.k_i > c_kw'(K_MAX))
            w_k_eff = c_kw'(K_MAX);
        else
            w_k_eff = bus.k_i;
    end

    // The array is kept sorted, so the insert slot is simply the number of
    // valid entries the new element fails to beat; ties keep arrival order.
    always_comb begin
        w_cur = beat_q[lane_q];
        w_pos = '0;
        for (int e = 0; e < K_MAX; e++) begin
            if ((c_kw'(e) < count_q) && !f_beats(w_cur, res_q[e], sign_q, desc_q))
                w_pos = w_pos + c_kw'(1);
        end
        for (int i = 0; i < K_MAX; i++) begin
            res_d[i] = res_q[i];
            if (w_pos < k_eff_q) begin
                if (c_kw'(i) == w_pos)
                    res_d[i] = w_cur;
                else if ((c_kw'(i) > w_pos) && (c_kw'(i) < k_eff_q))
                    res_d[i] = res_q[(i == 0) ? 0 : i - 1];
            end
        end
        count_d = count_q;
        if ((w_pos < k_eff_q) && (count_q < k_eff_q))
            count_d = count_q + c_kw'(1);
        rem_d = (rem_q != '0) ? rem_q - LEN_W'(1) : rem_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            beat_q      <= '0;
            rem_q       <= '0;
            k_eff_q     <= '0;
            sign_q      <= 1'b0;
            desc_q      <= 1'b0;
            lane_q      <= '0;
            res_q       <= '0;
            count_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid_i) begin
                        beat_q     <= bus.x_i;
                        rem_q      <= bus.in_len_i;
                        k_eff_q    <= w_k_eff;
                        sign_q     <= bus.sign_ctrl_i;
                        desc_q     <= bus.desc_i;
                        res_q      <= '0;
                        count_q    <= '0;
                        lane_q     <= '0;
                        in_ready_q <= 1'b0;
                        if (bus.in_len_i == '0) begin
                            state_q     <= S_OUT;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q <= S_INSERT;
                        end
                    end
                end
                S_INSERT: begin
                    if (rem_q != '0) begin
                        res_q   <= res_d;
                        count_q <= count_d;
                    end
                    rem_q  <= rem_d;
                    lane_q <= lane_q + c_lw'(1);
                    if (rem_d == '0) begin
                        state_q     <= S_OUT;
                        out_valid_q <= 1'b1;
                    end else if (lane_q == c_lw'(LANES - 1)) begin
                        state_q    <= S_WAIT_BEAT;
                        in_ready_q <= 1'b1;
                    end
                end
                S_WAIT_BEAT: begin
                    if (bus.in_valid_i) begin
                        beat_q     <= bus.x_i;
                        lane_q     <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= S_INSERT;
                    end
                end
                S_OUT: begin
                    if (bus.out_ready_i) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready_o  = in_ready_q;
    assign bus.out_valid_o = out_valid_q;
    assign bus.y_o         = res_q;
    assign bus.out_count_o = count_q;
endmodule
`default_nettype wire

// File: tb/tb_topk_stream_sorter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_topk_stream_sorter                                                      |
// | Directed table of frames plus backpressure and mid-frame reset sequences.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_topk_stream_sorter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    topk_stream_sorter_if #(.DATAWIDTH(8), .LANES(4), .K_MAX(8), .LEN_W(8)) bus ();

    topk_stream_sorter #(.DATAWIDTH(8), .LANES(4), .K_MAX(8), .LEN_W(8)) u_dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    typedef struct packed {
        logic                  sign;
        logic                  desc;
        logic [3:0]            k;
        logic [7:0]            len;
        logic [2:0][3:0][7:0]  beats;
        logic [3:0]            cnt;
        logic [7:0][7:0]       y;
        logic [7:0]            lat;
    } vec_t;

    vec_t vecs [9];

    function automatic logic [3:0][7:0] bt(input logic [7:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    function automatic logic [7:0][7:0] yv(input logic [7:0] a0, a1, a2, a3, a4, a5, a6, a7);
        return {a7, a6, a5, a4, a3, a2, a1, a0};
    endfunction

    function automatic vec_t mk(input logic sg, input logic ds, input logic [3:0] k,
                                input logic [7:0] len, input logic [3:0][7:0] b0,
                                input logic [3:0][7:0] b1, input logic [3:0][7:0] b2,
                                input logic [3:0] cnt, input logic [7:0][7:0] y,
                                input logic [7:0] lat);
        vec_t v;
        v.sign = sg; v.desc = ds; v.k = k; v.len = len;
        v.beats = {b2, b1, b0};
        v.cnt = cnt; v.y = y; v.lat = lat;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drives a frame with in_valid held high; returns edges from accept to out_valid (-1 on timeout).
    task automatic launch(input vec_t v, input string nm, output int edges);
        int b;
        @(negedge clk);
        chk({nm, "_idle_rdy"}, 64'(bus.in_ready_o), 64'd1);
        bus.in_valid_i  = 1'b1;
        bus.in_len_i    = v.len;
        bus.k_i         = v.k;
        bus.sign_ctrl_i = v.sign;
        bus.desc_i      = v.desc;
        bus.x_i         = v.beats[0];
        @(posedge clk);
        edges = 0;
        b = 1;
        while (1) begin
            @(negedge clk);
            if (bus.out_valid_o) break;
            if (edges >= 60) begin
                edges = -1;
                break;
            end
            if (bus.in_ready_o && b < 3) begin
                bus.x_i = v.beats[b];
                b++;
            end
            @(posedge clk);
            edges++;
        end
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        int edges;
        launch(v, nm, edges);
        bus.in_valid_i = 1'b0;
        chk({nm, "_lat"},   64'(edges), 64'(v.lat));
        chk({nm, "_cnt"},   64'(bus.out_count_o), 64'(v.cnt));
        chk({nm, "_y"},     bus.y_o, v.y);
        chk({nm, "_excl"},  64'(bus.in_ready_o), 64'd0);
        bus.out_ready_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready_i = 1'b0;
        chk({nm, "_done"},  64'(bus.out_valid_o), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int edges;
        bus.in_valid_i  = 1'b0;
        bus.in_len_i    = '0;
        bus.k_i         = '0;
        bus.sign_ctrl_i = 1'b0;
        bus.desc_i      = 1'b0;
        bus.x_i         = '0;
        bus.out_ready_i = 1'b0;

        vecs[0] = mk(0, 1, 4, 8,  bt(5, 7, 9, 1), bt(0, 2, 3, 6), '0, 4,
                     yv(9, 7, 6, 5, 0, 0, 0, 0), 9);
        vecs[1] = mk(1, 0, 3, 4,  bt(8'h9C, 8'h19, 8'hFB, 8'h00), '0, '0, 3,
                     yv(8'h9C, 8'hFB, 8'h00, 0, 0, 0, 0, 0), 4);
        vecs[2] = mk(0, 0, 3, 4,  bt(8'h9C, 8'h19, 8'hFB, 8'h00), '0, '0, 3,
                     yv(8'h00, 8'h19, 8'h9C, 0, 0, 0, 0, 0), 4);
        vecs[3] = mk(0, 1, 8, 6,  bt(5, 7, 9, 1), bt(0, 2, 99, 99), '0, 6,
                     yv(9, 7, 5, 2, 1, 0, 0, 0), 7);
        vecs[4] = mk(0, 1, 4, 0,  bt(11, 22, 33, 44), '0, '0, 0,
                     yv(0, 0, 0, 0, 0, 0, 0, 0), 0);
        vecs[5] = mk(0, 1, 12, 10, bt(1, 2, 3, 4), bt(5, 6, 7, 8), bt(9, 10, 11, 12), 8,
                     yv(10, 9, 8, 7, 6, 5, 4, 3), 12);
        vecs[6] = mk(0, 0, 0, 5,  bt(7, 3, 9, 3), bt(1, 200, 0, 0), '0, 1,
                     yv(1, 0, 0, 0, 0, 0, 0, 0), 6);
        vecs[7] = mk(1, 1, 2, 3,  bt(3, 3, 8'hFF, 8'h7F), '0, '0, 2,
                     yv(3, 3, 0, 0, 0, 0, 0, 0), 3);
        vecs[8] = mk(1, 1, 4, 4,  bt(8'hFF, 8'h80, 8'h7F, 8'h00), '0, '0, 4,
                     yv(8'h7F, 8'h00, 8'hFF, 8'h80, 0, 0, 0, 0), 4);

        @(negedge clk);
        chk("rst_ready", 64'(bus.in_ready_o), 64'd1);
        chk("rst_valid", 64'(bus.out_valid_o), 64'd0);
        chk("rst_count", 64'(bus.out_count_o), 64'd0);
        chk("rst_y",     bus.y_o, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 9; i++)
            run_vec(vecs[i], $sformatf("v%0d", i));

        // Backpressure: result must hold while the next frame waits.
        launch(vecs[1], "bp", edges);
        chk("bp_lat", 64'(edges), 64'd4);
        bus.in_len_i    = 8'd1;
        bus.k_i         = 4'd1;
        bus.sign_ctrl_i = 1'b0;
        bus.desc_i      = 1'b1;
        bus.x_i         = bt(42, 0, 0, 0);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("bp_hold%0d_rdy", c), 64'(bus.in_ready_o), 64'd0);
            chk($sformatf("bp_hold%0d_vld", c), 64'(bus.out_valid_o), 64'd1);
            chk($sformatf("bp_hold%0d_y", c), bus.y_o, vecs[1].y);
        end
        bus.out_ready_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready_i = 1'b0;
        chk("bp_after_vld", 64'(bus.out_valid_o), 64'd0);
        chk("bp_after_rdy", 64'(bus.in_ready_o), 64'd1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid_i = 1'b0;
        chk("bp_next_taken", 64'(bus.in_ready_o), 64'd0);
        @(posedge clk);
        @(negedge clk);
        chk("bp_next_vld", 64'(bus.out_valid_o), 64'd1);
        chk("bp_next_y",   bus.y_o, yv(42, 0, 0, 0, 0, 0, 0, 0));
        chk("bp_next_cnt", 64'(bus.out_count_o), 64'd1);
        bus.out_ready_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready_i = 1'b0;

        // Reset in the middle of a three-beat frame.
        bus.in_valid_i  = 1'b1;
        bus.in_len_i    = vecs[5].len;
        bus.k_i         = vecs[5].k;
        bus.sign_ctrl_i = vecs[5].sign;
        bus.desc_i      = vecs[5].desc;
        bus.x_i         = vecs[5].beats[0];
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("mid_partial_cnt", 64'(bus.out_count_o), 64'd2);
        rst = 1'b1;
        #1;
        chk("mid_rst_rdy", 64'(bus.in_ready_o), 64'd1);
        chk("mid_rst_vld", 64'(bus.out_valid_o), 64'd0);
        chk("mid_rst_cnt", 64'(bus.out_count_o), 64'd0);
        chk("mid_rst_y",   bus.y_o, 64'd0);
        bus.in_valid_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        run_vec(vecs[5], "post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
